// File: rtl/microroc_readout_emu_if.sv
// Bus bundle between the DAQ readout logic and the Microroc readout emulator.
// Optional error-injection ports appear when MICROROC_EMU_ERRINJ_EN is defined.
//
// Handshake: start_readout is a level. Its rising edge requests one readout,
// and the request is only honoured while busy is low. busy stays high from
// acceptance through the single-cycle end_readout pulse, inclusive. A new
// readout needs start_readout to fall and rise again after busy has dropped.
interface microroc_readout_emu_if;
  logic        start_readout;
  logic [7:0]  chip_id;
  logic [7:0]  frame_count;
  logic [1:0]  pattern_mode;
  logic [23:0] bcid_base;
`ifdef MICROROC_EMU_ERRINJ_EN
  logic [7:0]  err_frame;
  logic        err_en;
`endif
  logic        dout_b;
  logic        transmiton_b;
  logic        end_readout;
  logic        busy;

`ifdef MICROROC_EMU_ERRINJ_EN
  modport master (
    output start_readout, chip_id, frame_count, pattern_mode, bcid_base,
    output err_frame, err_en,
    input  dout_b, transmiton_b, end_readout, busy
  );
  modport slave (
    input  start_readout, chip_id, frame_count, pattern_mode, bcid_base,
    input  err_frame, err_en,
    output dout_b, transmiton_b, end_readout, busy
  );
`else
  modport master (
    output start_readout, chip_id, frame_count, pattern_mode, bcid_base,
    input  dout_b, transmiton_b, end_readout, busy
  );
  modport slave (
    input  start_readout, chip_id, frame_count, pattern_mode, bcid_base,
    output dout_b, transmiton_b, end_readout, busy
  );
`endif
endinterface

// File: rtl/microroc_readout_emu.sv
// Microroc RAM-readout transmitter emulator.
// On an accepted start it sends frame_count frames of 160 bits, MSB first:
// {bcid[23:0], hit[127:0], chip_id[7:0]}. dout_b is active low and
// transmiton_b is low while frame bits are on the line. end_readout pulses
// once when the readout completes.
// Optional feature: MICROROC_EMU_ERRINJ_EN adds err_frame/err_en, which invert
// chip_id bit 0 in one chosen frame.
module microroc_readout_emu #(
  parameter int CLK_DIV    = 8,    // clocks per serial bit, 2..255
  parameter int GAP_BITS   = 4,    // idle bit periods between frames
  parameter int FRAME_BITS = 160   // frame layout is fixed; leave at 160
) (
  input  logic                         Clk,
  input  logic                         reset,
  microroc_readout_emu_if.slave        bus,
  output logic [2:0]                   o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [7:0]  BIT_LAST = 8'(FRAME_BITS - 1);
  // A zero-length gap degenerates to a single idle cycle before LOAD.
  localparam logic [15:0] GAP_LAST = 16'((GAP_BITS > 0) ? (GAP_BITS * CLK_DIV - 1) : 0);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  state_t        r_state;
  state_t        w_state_nxt;

  logic          r_start_q;      // synchronised start level
  logic          r_start_d;      // previous sample, for edge detect
  logic          w_rise;

  logic          r_busy;
  logic          r_end;
  logic          r_dout_b;
  logic          r_txon_b;

  logic [159:0]  r_shreg;
  logic [15:0]   r_cnt;          // bit-period counter in SEND, gap counter in GAP
  logic [7:0]    r_bit;          // bit index within the frame
  logic [7:0]    r_frame_idx;
  logic [15:0]   r_lfsr;

  // Readout configuration captured at the first LOAD of a readout.
  logic [7:0]    r_nframes;
  logic [7:0]    r_chip;
  logic [1:0]    r_mode;
  logic [23:0]   r_base;

  logic          w_first;
  logic [7:0]    w_nframes;
  logic [7:0]    w_chip;
  logic [1:0]    w_mode;
  logic [23:0]   w_base;
  logic [7:0]    w_chip_tx;
  logic [23:0]   w_bcid;
  logic [127:0]  w_hit;
  logic [159:0]  w_frame;
  logic [15:0]   w_lfsr_nxt;
  logic          w_bit_end;
  logic          w_last_bit;
  logic          w_last_frame;

`ifdef MICROROC_EMU_ERRINJ_EN
  logic [7:0]    r_err_frame;
  logic          r_err_en;
`endif

  assign w_rise = r_start_q & ~r_start_d;

  // The first LOAD of a readout (frame_idx still 0) samples live inputs;
  // every later LOAD reuses the captured copy so mid-readout changes are ignored.
  assign w_first   = (r_frame_idx == 8'd0);
  assign w_nframes = w_first ? bus.frame_count  : r_nframes;
  assign w_chip    = w_first ? bus.chip_id      : r_chip;
  assign w_mode    = w_first ? bus.pattern_mode : r_mode;
  assign w_base    = w_first ? bus.bcid_base    : r_base;

`ifdef MICROROC_EMU_ERRINJ_EN
  assign w_chip_tx = w_chip ^ {7'd0, (r_err_en && (r_frame_idx == r_err_frame))};
`else
  assign w_chip_tx = w_chip;
`endif

  assign w_bcid = w_base + {16'd0, r_frame_idx};

  // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1, shifting right.
  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  // Hit payload selection for the frame being loaded.
  always_comb begin
    w_hit = '0;
    case (w_mode)
      2'd0:    w_hit = '0;
      2'd1:    w_hit = '1;
      2'd2:    w_hit = {16{r_frame_idx}};
      default: w_hit = {8{r_lfsr}};
    endcase
  end

  assign w_frame      = {w_bcid, w_hit, w_chip_tx};
  assign w_bit_end    = (r_cnt == DIV_LAST);
  assign w_last_bit   = (r_bit == BIT_LAST);
  // Compared before the increment, so frame_count = 255 gives 255 frames.
  assign w_last_frame = (r_frame_idx == (r_nframes - 8'd1));

  // State register.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_rise && !r_busy) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = (w_nframes == 8'd0) ? S_DONE : S_SEND;
      S_SEND: if (w_bit_end && w_last_bit) w_state_nxt = w_last_frame ? S_DONE : S_GAP;
      S_GAP:  if (r_cnt == GAP_LAST) w_state_nxt = S_LOAD;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Start edge detect, busy/end flags and the serialiser datapath.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_start_q   <= 1'b0;
      r_start_d   <= 1'b0;
      r_busy      <= 1'b0;
      r_end       <= 1'b0;
      r_dout_b    <= 1'b1;
      r_txon_b    <= 1'b1;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_frame_idx <= '0;
      r_lfsr      <= LFSR_SEED;
      r_nframes   <= '0;
      r_chip      <= '0;
      r_mode      <= '0;
      r_base      <= '0;
`ifdef MICROROC_EMU_ERRINJ_EN
      r_err_frame <= '0;
      r_err_en    <= 1'b0;
`endif
    end else begin
      r_start_q <= bus.start_readout;
      r_start_d <= r_start_q;
      r_end     <= (r_state == S_DONE);
      // busy drops on the edge after the end_readout pulse.
      if (r_end) r_busy <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_state_nxt == S_LOAD) begin
            r_busy      <= 1'b1;
            r_frame_idx <= 8'd0;
`ifdef MICROROC_EMU_ERRINJ_EN
            r_err_frame <= bus.err_frame;
            r_err_en    <= bus.err_en;
`endif
          end
        end

        S_LOAD: begin
          if (w_first) begin
            r_nframes <= bus.frame_count;
            r_chip    <= bus.chip_id;
            r_mode    <= bus.pattern_mode;
            r_base    <= bus.bcid_base;
          end
          if (w_nframes != 8'd0) begin
            r_shreg  <= w_frame;
            r_dout_b <= ~w_frame[159];
            r_txon_b <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= '0;
            if (w_mode == 2'd3) r_lfsr <= w_lfsr_nxt;
          end
        end

        S_SEND: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_last_bit) begin
              r_txon_b    <= 1'b1;
              r_dout_b    <= 1'b1;
              r_frame_idx <= r_frame_idx + 8'd1;
            end else begin
              r_bit    <= r_bit + 8'd1;
              r_shreg  <= {r_shreg[158:0], 1'b0};
              r_dout_b <= ~r_shreg[158];
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_GAP: r_cnt <= r_cnt + 16'd1;

        default: ;
      endcase
    end
  end

  assign bus.dout_b       = r_dout_b;
  assign bus.transmiton_b = r_txon_b;
  assign bus.end_readout  = r_end;
  assign bus.busy         = r_busy;
  assign o_dbg_state      = r_state;

endmodule
